dbus_sram_responder: RTL and testbench

Responder end of the core's data-bus request/response protocol: accepts one dbus request at a time, waits a programmable latency, then completes it against an internal 64-bit-wide SRAM array with byte-strobe writes. Used as the on-chip data memory / bench memory model behind the core's dreq/dresp ports. Protocol and timing match what the core's memory stage expects: the request is held valid until data_ok.

---
 rtl/dbus_sram_responder_if.sv | 21 ++
 rtl/dbus_sram_responder.sv | 86 ++++++++
 tb/tb_dbus_sram_responder.sv | 116 +++++++++++
 3 files changed

// File: rtl/dbus_sram_responder_if.sv
// dbus_sram_responder_if: dbus request/response bundle between the core-side initiator and the responder
interface dbus_sram_responder_if;
  logic        req_valid;
  logic [63:0] req_addr;
  logic [2:0]  req_size;
  logic [7:0]  req_strobe;
  logic [63:0] req_data;
  logic        resp_addr_ok;
  logic        resp_data_ok;
  logic [63:0] resp_data;
  logic        err_oor;
  logic [31:0] served_cnt;
  modport master (
    output req_valid, req_addr, req_size, req_strobe, req_data,
    input  resp_addr_ok, resp_data_ok, resp_data, err_oor, served_cnt
  );
  modport slave (
    input  req_valid, req_addr, req_size, req_strobe, req_data,
    output resp_addr_ok, resp_data_ok, resp_data, err_oor, served_cnt
  );
endinterface

// File: rtl/dbus_sram_responder.sv
// dbus_sram_responder: one-at-a-time dbus responder with programmable latency over a byte-strobed 64-bit SRAM.
// Define DBUS_RESP_RAND_STALL_EN to add 0..3 LFSR-driven extra wait cycles per request.
module dbus_sram_responder #(
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned LATENCY   = 2,
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
  input logic            clk,
  input logic            reset,
  dbus_sram_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2;
  logic [1:0]    state_q, state_d;
  logic [4:0]    cnt_q, cnt_d, load;
  logic [63:0]   addr_q, addr_d, data_q, data_d, off;
  logic [7:0]    strobe_q, strobe_d;
  logic [2:0]    size_q, size_d;
  logic          err_q, err_d;
  logic [31:0]   served_q, served_d;
  logic [1:0]    extra;
  logic [AW-1:0] idx;
  logic          in_range, accept, done, wr;
  logic          unused_bits;
  logic [63:0]   mem [DEPTH];
`ifdef DBUS_RESP_RAND_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;
  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    extra  = lfsr_q[1:0];
  end
  always_ff @(posedge clk)
    lfsr_q <= reset ? 16'hACE1 : lfsr_d;
`else
  always_comb extra = 2'd0;
`endif
  always_comb begin
    off      = addr_q - BASE_ADDR;
    idx      = off[AW+2:3];
    in_range = (addr_q >= BASE_ADDR) && (off[63:3] < 61'(DEPTH));
    accept   = (state_q == IDLE) && bus.req_valid && !reset;
    done     = (state_q == DONE) && !reset;
    wr       = done && in_range && |strobe_q;
    load     = 5'(LATENCY - 1) + 5'(extra);
    state_d  = accept ? (load == 5'd0 ? DONE : WAIT)
             : (state_q == WAIT) ? (cnt_q == 5'd1 ? DONE : WAIT) : IDLE;
    cnt_d    = accept ? load : (state_q == WAIT) ? cnt_q - 5'd1 : cnt_q;
    addr_d   = accept ? bus.req_addr : addr_q;
    data_d   = accept ? bus.req_data : data_q;
    strobe_d = accept ? bus.req_strobe : strobe_q;
    size_d   = accept ? bus.req_size : size_q;
    err_d    = err_q | (done && !in_range);
    served_d = served_q + 32'(done);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      strobe_q <= '0;
      size_q   <= '0;
      err_q    <= 1'b0;
      served_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      strobe_q <= strobe_d;
      size_q   <= size_d;
      err_q    <= err_d;
      served_q <= served_d;
    end
  end
  // array is deliberately left unreset; only strobed lanes of an in-range word change
  always_ff @(posedge clk)
    for (int i = 0; i < 8; i++)
      if (wr && strobe_q[i]) mem[idx][8*i +: 8] <= data_q[8*i +: 8];
  assign bus.resp_addr_ok = accept;
  assign bus.resp_data_ok = done;
  assign bus.resp_data    = (done && in_range && ~|strobe_q) ? mem[idx] : 64'd0;
  assign bus.err_oor      = err_q;
  assign bus.served_cnt   = served_q;
  assign unused_bits      = ^{size_q, off[2:0]};
endmodule

// File: tb/tb_dbus_sram_responder.sv
// tb_dbus_sram_responder: directed table-driven checks of the dbus SRAM responder plus reset/latency corner sequences
module tb_dbus_sram_responder;
  logic clk, reset;
  int checks = 0, errors = 0;
  dbus_sram_responder_if m();
  dbus_sram_responder_if m1();
  dbus_sram_responder #(.DEPTH(1024), .LATENCY(2)) dut (.clk(clk), .reset(reset), .bus(m));
  dbus_sram_responder #(.DEPTH(1024), .LATENCY(1)) dut1 (.clk(clk), .reset(reset), .bus(m1));
  always #5 clk = ~clk;
  typedef struct {
    logic [63:0] a;
    logic [7:0]  s;
    logic [63:0] d;
    logic [63:0] rd;
    logic        err;
  } vec_t;
  vec_t v[11];
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic txn(input logic [63:0] a, input logic [7:0] s, input logic [63:0] d, input bit g,
                     output logic [63:0] rd, output int lat);
    m.req_valid = 1; m.req_addr = a; m.req_strobe = s; m.req_data = d; m.req_size = 3'd3;
    @(negedge clk);
    chk("addr_ok", 64'(m.resp_addr_ok), 64'd1);
    @(posedge clk); #1;
    if (g) begin
      m.req_strobe = 8'h00; m.req_data = 64'hFFFF_FFFF_FFFF_FFFF; m.req_addr = 64'h8000_0030;
    end
    lat = 0; rd = '0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (m.resp_data_ok) begin
        lat = i; rd = m.resp_data;
        break;
      end
    end
    @(posedge clk); #1;
    m.req_valid = 0;
  endtask
  initial begin
    logic [63:0] rd;
    int lat, pulses;
    v[0]  = '{64'h8000_0000, 8'hFF, 64'h0123_4567_89AB_CDEF, 64'h0, 1'b0};
    v[1]  = '{64'h8000_0010, 8'hFF, 64'h1122_3344_5566_7788, 64'h0, 1'b0};
    v[2]  = '{64'h8000_0010, 8'h00, 64'h0, 64'h1122_3344_5566_7788, 1'b0};
    v[3]  = '{64'h8000_0010, 8'h0F, 64'hAAAA_AAAA_BBBB_BBBB, 64'h0, 1'b0};
    v[4]  = '{64'h8000_0015, 8'h00, 64'h0, 64'h1122_3344_BBBB_BBBB, 1'b0};
    v[5]  = '{64'h8000_0020, 8'hFF, 64'h0F0F_0F0F_0F0F_0F0F, 64'h0, 1'b0};
    v[6]  = '{64'h7FFF_FFF8, 8'h00, 64'h0, 64'h0, 1'b1};
    v[7]  = '{64'h8000_2000, 8'h00, 64'h0, 64'h0, 1'b1};
    v[8]  = '{64'h8000_2000, 8'hFF, 64'hBADB_ADBA_DBAD_BAD0, 64'h0, 1'b1};
    v[9]  = '{64'h8000_0000, 8'h00, 64'h0, 64'h0123_4567_89AB_CDEF, 1'b1};
    v[10] = '{64'h8000_0020, 8'h00, 64'h0, 64'h0F0F_0F0F_0F0F_0F0F, 1'b1};
    clk = 0; reset = 1;
    m.req_valid = 0; m.req_addr = '0; m.req_size = '0; m.req_strobe = '0; m.req_data = '0;
    m1.req_valid = 0; m1.req_addr = '0; m1.req_size = '0; m1.req_strobe = '0; m1.req_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_addr_ok", 64'(m.resp_addr_ok), 64'd0);
    chk("rst_data_ok", 64'(m.resp_data_ok), 64'd0);
    chk("rst_data", m.resp_data, 64'd0);
    chk("rst_err", 64'(m.err_oor), 64'd0);
    chk("rst_served", 64'(m.served_cnt), 64'd0);
    @(posedge clk); #1;
    reset = 0;
    for (int i = 0; i < 11; i++) begin
      txn(v[i].a, v[i].s, v[i].d, 1'b0, rd, lat);
      chk($sformatf("lat[%0d]", i), 64'(lat), 64'd2);
      chk($sformatf("rdata[%0d]", i), rd, v[i].rd);
      chk($sformatf("err[%0d]", i), 64'(m.err_oor), 64'(v[i].err));
      chk($sformatf("served[%0d]", i), 64'(m.served_cnt), 64'(i + 1));
    end
    txn(64'h8000_0028, 8'hFF, 64'h5555_6666_7777_8888, 1'b1, rd, lat);
    chk("garbage_lat", 64'(lat), 64'd2);
    txn(64'h8000_0028, 8'h00, 64'h0, 1'b0, rd, lat);
    chk("garbage_rd", rd, 64'h5555_6666_7777_8888);
    m.req_valid = 1; m.req_addr = 64'h8000_0020; m.req_strobe = 8'hFF; m.req_data = 64'hCAFE_CAFE_CAFE_CAFE;
    @(negedge clk);
    chk("abort_addr_ok", 64'(m.resp_addr_ok), 64'd1);
    @(posedge clk); #1;
    reset = 1;
    @(negedge clk);
    chk("abort_wait_data_ok", 64'(m.resp_data_ok), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_addr_ok_rst", 64'(m.resp_addr_ok), 64'd0);
    chk("abort_data_ok", 64'(m.resp_data_ok), 64'd0);
    chk("abort_data", m.resp_data, 64'd0);
    chk("abort_err", 64'(m.err_oor), 64'd0);
    chk("abort_served", 64'(m.served_cnt), 64'd0);
    @(posedge clk); #1;
    m.req_valid = 0; reset = 0;
    txn(64'h8000_0020, 8'h00, 64'h0, 1'b0, rd, lat);
    chk("abort_rd", rd, 64'h0F0F_0F0F_0F0F_0F0F);
    chk("abort_rd_lat", 64'(lat), 64'd2);
    m1.req_valid = 1; m1.req_addr = 64'h8000_0000; m1.req_strobe = 8'h00;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("l1_addr_ok[%0d]", k), 64'(m1.resp_addr_ok), 64'(k % 2 == 0));
      chk($sformatf("l1_data_ok[%0d]", k), 64'(m1.resp_data_ok), 64'(k % 2 == 1));
      if (m1.resp_data_ok) pulses++;
    end
    @(posedge clk); #1;
    m1.req_valid = 0;
    chk("l1_pulses", 64'(pulses), 64'd5);
    chk("l1_served", 64'(m1.served_cnt), 64'(pulses));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
